// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit.
// Holds funct3/cause/state enums and access-size helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_WAIT0,
        S_ACC1,
        S_WAIT1,
        S_RESP
    } state_e;

    // Byte lanes touched by an access of size sz, starting at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Offset of the last byte of the access from its first byte.
    function automatic logic [1:0] size_last(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // 011/110/111 never legal; unsigned encodings have no store form.
    function automatic logic f3_illegal(input logic [2:0] f3,
                                        input logic       wr);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (wr && f3[2]);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between execute stage and unit.
// master: pipeline side (req_*, resp_ready); slave: the unit.
interface mem_access_unit_if;
    import mem_access_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    cause_e      resp_cause;

    modport master (
        output req_valid, req_addr, req_funct3, req_write, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
    );

    modport slave (
        input  req_valid, req_addr, req_funct3, req_write, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Lane steering for one access half plus load extract/extend.
// Ports: half_i/off_i/funct3_i/wdata_i -> wdata_o/be_o; rlo_i/rhi_i -> rdata_o.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic        half_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rlo_i,
    input  logic [31:0] rhi_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shamt;
    logic [7:0]  be8;
    logic [63:0] w64;
    logic [31:0] raw;

    assign shamt = {off_i, 3'b000};

    // Upper halves of the shifted vectors are the second-word lanes.
    assign be8 = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
    assign w64 = {32'b0, wdata_i} << shamt;

    assign be_o    = half_i ? be8[7:4]   : be8[3:0];
    assign wdata_o = half_i ? w64[63:32] : w64[31:0];

    assign raw = 32'({rhi_i, rlo_i} >> shamt);

    always_comb begin
        rdata_o = raw;
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   rdata_o = {24'b0, raw[7:0]};
            F3_HU:   rdata_o = {16'b0, raw[15:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for one byte-enabled, 1-cycle-latency BRAM port.
// Ports: clk, rst, bus (slave handshake), mem_addr/wdata/data_en/write_en/rdata.
// MEM_ACCESS_SPLIT_EN: split word-crossing accesses into two word accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int MEM_SIZE = 8192,
    localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    mem_access_unit_if.slave    bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_data_en,
    output logic                mem_write_en,
    input  logic [31:0]         mem_rdata
);

    state_e              state_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [31:0]         wdata_q;
    logic                write_q;
    logic                resp_valid_q;
    logic                resp_fault_q;
    logic [31:0]         resp_rdata_q;
    cause_e              resp_cause_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_be_q;
    logic                mem_we_q;
`ifdef MEM_ACCESS_SPLIT_EN
    logic                split_q;
    logic [31:0]         w0_q;
`endif

    logic [1:0]          req_off;
    logic [1:0]          req_last;
    logic [ADDR_W:0]     req_end;
    logic                req_cross;
    logic                req_oor;
    cause_e              cause_d;

    assign req_off   = bus.req_addr[1:0];
    assign req_last  = size_last(bus.req_funct3[1:0]);
    // MEM_SIZE is a power of two: a carry out of the low bits is out of range.
    assign req_end   = {1'b0, bus.req_addr[ADDR_W-1:0]}
                     + (ADDR_W+1)'(req_last);
    assign req_cross = ({1'b0, req_off} + {1'b0, req_last}) > 3'd3;
    assign req_oor   = (|bus.req_addr[31:ADDR_W]) | req_end[ADDR_W];

    always_comb begin
        cause_d = CAUSE_NONE;
        if (f3_illegal(bus.req_funct3, bus.req_write)) begin
            cause_d = CAUSE_ILLEGAL;
        end else if (req_oor) begin
            cause_d = CAUSE_RANGE;
`ifndef MEM_ACCESS_SPLIT_EN
        end else if (req_cross) begin
            cause_d = CAUSE_MISALIGN;
`endif
        end
    end

    // One aligner shared by both halves: request fields while idle
    // (first half), latched fields afterwards (second half, read path).
    logic        al_half;
    logic [1:0]  al_off;
    logic [2:0]  al_f3;
    logic [31:0] al_wd;
    logic [31:0] al_rlo;
    logic [31:0] al_rhi;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_rdata;

    assign al_half = (state_q != S_IDLE);
    assign al_off  = al_half ? off_q   : req_off;
    assign al_f3   = al_half ? f3_q    : bus.req_funct3;
    assign al_wd   = al_half ? wdata_q : bus.req_wdata;
`ifdef MEM_ACCESS_SPLIT_EN
    assign al_rlo  = (state_q == S_WAIT1) ? w0_q : mem_rdata;
    assign al_rhi  = (state_q == S_WAIT1) ? mem_rdata : 32'b0;
`else
    assign al_rlo  = mem_rdata;
    assign al_rhi  = 32'b0;
`endif

    mem_lane_align u_align (
        .half_i   (al_half),
        .off_i    (al_off),
        .funct3_i (al_f3),
        .wdata_i  (al_wd),
        .rlo_i    (al_rlo),
        .rhi_i    (al_rhi),
        .wdata_o  (al_wdata),
        .be_o     (al_be),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_cause_q <= CAUSE_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'b0;
            mem_be_q     <= 4'b0;
            mem_we_q     <= 1'b0;
        end else begin
            mem_be_q <= 4'b0;
            mem_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    f3_q    <= bus.req_funct3;
                    off_q   <= req_off;
                    wdata_q <= bus.req_wdata;
                    write_q <= bus.req_write;
`ifdef MEM_ACCESS_SPLIT_EN
                    split_q <= req_cross;
`endif
                    if (cause_d != CAUSE_NONE) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_cause_q <= cause_d;
                        resp_rdata_q <= 32'b0;
                    end else begin
                        state_q     <= S_ACC0;
                        mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= al_wdata;
                        mem_be_q    <= al_be;
                        mem_we_q    <= bus.req_write;
                    end
                end
                S_ACC0: state_q <= S_WAIT0;
                S_WAIT0: begin
`ifdef MEM_ACCESS_SPLIT_EN
                    if (split_q) begin
                        w0_q        <= mem_rdata;
                        state_q     <= S_ACC1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                        mem_wdata_q <= al_wdata;
                        mem_be_q    <= al_be;
                        mem_we_q    <= write_q;
                    end else
`endif
                    begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_cause_q <= CAUSE_NONE;
                        resp_rdata_q <= write_q ? 32'b0 : al_rdata;
                    end
                end
`ifdef MEM_ACCESS_SPLIT_EN
                S_ACC1: state_q <= S_WAIT1;
                S_WAIT1: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_cause_q <= CAUSE_NONE;
                    resp_rdata_q <= write_q ? 32'b0 : al_rdata;
                end
`endif
                S_RESP: if (bus.resp_ready) begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_cause = resp_cause_q;

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_data_en  = mem_be_q;
    // Strobe is masked by reset so an abandoned store never lands.
    assign mem_write_en = mem_we_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-lane BRAM model.
// Table of request vectors plus reset and backpressure sequences.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_data_en;
    logic        mem_write_en;

    mem_access_unit #(.MEM_SIZE(8192)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    logic [7:0]  mem [0:8191];
    logic        clr = 1'b1;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    logic [12:0] lw_addr;
    logic [3:0]  lw_en;
    logic [31:0] lw_data;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_write_en && mem_data_en[b])
                    mem[mem_addr + 13'(b)] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= {mem[mem_addr + 13'd3], mem[mem_addr + 13'd2],
                      mem[mem_addr + 13'd1], mem[mem_addr]};
        if (mem_write_en) begin
            wr_cnt  <= wr_cnt + 1;
            lw_addr <= mem_addr;
            lw_en   <= mem_data_en;
            lw_data <= mem_wdata;
        end
        if (mem_data_en != 4'b0) acc_cnt <= acc_cnt + 1;
    end

    typedef struct {
        string       name;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          fault;
        logic [1:0]  cause;
        int          lat;
        int          nwr;
        int          nacc;
        bit          chkw;
        logic [12:0] waddr;
        logic [3:0]  wen;
        logic [31:0] wval;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          fault;
        logic [1:0]  cause;
    } resp_t;

    vec_t  vt[$];
    resp_t sb[$];
    int    ncmp = 0;
    int    nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input bit wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input bit flt, input logic [1:0] c,
                                input int lat, input int nwr, input int nacc,
                                input bit chkw = 1'b0,
                                input logic [12:0] wa = 13'd0,
                                input logic [3:0] we = 4'd0,
                                input logic [31:0] wv = 32'd0);
        vec_t v;
        v.name = nm; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.fault = flt; v.cause = c; v.lat = lat;
        v.nwr = nwr; v.nacc = nacc; v.chkw = chkw; v.waddr = wa;
        v.wen = we; v.wval = wv;
        vt.push_back(v);
    endfunction

    task automatic run(input vec_t v);
        int    w0, a0, lat;
        bit    got;
        resp_t e;
        @(negedge clk);
        bus.req_addr   = v.addr;
        bus.req_funct3 = v.f3;
        bus.req_write  = v.wr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.req_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk({v.name, ".accept"}, 32'(got), 32'd1);
        if (!got) begin
            bus.req_valid = 1'b0;
            return;
        end
        w0 = wr_cnt;
        a0 = acc_cnt;
        sb.push_back('{v.rdata, v.fault, v.cause});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) got = 1'b1;
        end
        chk({v.name, ".resp"}, 32'(got), 32'd1);
        if (!got) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk({v.name, ".rdata"}, bus.resp_rdata, e.rdata);
        chk({v.name, ".fault"}, 32'(bus.resp_fault), 32'(e.fault));
        chk({v.name, ".cause"}, 32'(bus.resp_cause), 32'(e.cause));
        chk({v.name, ".lat"}, 32'(lat), 32'(v.lat));
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".writes"}, 32'(wr_cnt - w0), 32'(v.nwr));
        chk({v.name, ".accesses"}, 32'(acc_cnt - a0), 32'(v.nacc));
        if (v.chkw) begin
            chk({v.name, ".waddr"}, 32'(lw_addr), 32'(v.waddr));
            chk({v.name, ".wen"}, 32'(lw_en), 32'(v.wen));
            chk({v.name, ".wdata"}, lw_data, v.wval);
        end
    endtask

    initial begin
        int  w0;
        int  n;
        bit  seen;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'b0;
        bus.req_funct3 = 3'b0;
        bus.req_write  = 1'b0;
        bus.req_wdata  = 32'b0;
        bus.resp_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.resp_fault", 32'(bus.resp_fault), 32'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst.resp_cause", 32'(bus.resp_cause), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.data_en", 32'(mem_data_en), 32'd0);
        chk("rst.write_en", 32'(mem_write_en), 32'd0);
        clr = 1'b0;
        rst = 1'b0;

        add("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2'd0, 3, 1, 1,
            1, 13'h10, 4'b1111, 32'hDEADBEEF);
        add("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2'd0, 3, 0, 1);
        add("sb21", 1, 3'b000, 32'h21, 32'hA5, 32'h0, 0, 2'd0, 3, 1, 1,
            1, 13'h20, 4'b0010, 32'h0000A500);
        add("lb21", 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFA5, 0, 2'd0, 3, 0, 1);
        add("lbu21", 0, 3'b100, 32'h21, 32'h0, 32'h000000A5, 0, 2'd0, 3, 0, 1);
        add("sh31", 1, 3'b001, 32'h31, 32'h8001, 32'h0, 0, 2'd0, 3, 1, 1,
            1, 13'h30, 4'b0110, 32'h00800100);
        add("lh31", 0, 3'b001, 32'h31, 32'h0, 32'hFFFF8001, 0, 2'd0, 3, 0, 1);
        add("lhu31", 0, 3'b101, 32'h31, 32'h0, 32'h00008001, 0, 2'd0, 3, 0, 1);
        add("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h0000A500, 0, 2'd0, 3, 0, 1);
        add("lw2000", 0, 3'b010, 32'h2000, 32'h0, 32'h0, 1, 2'd2, 1, 0, 0);
        add("swhigh", 1, 3'b010, 32'h80000010, 32'h1, 32'h0, 1, 2'd2, 1, 0, 0);
        add("f3_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 2'd3, 1, 0, 0);
        add("sbu", 1, 3'b100, 32'h10, 32'h5, 32'h0, 1, 2'd3, 1, 0, 0);
        add("prio", 0, 3'b111, 32'h2001, 32'h0, 32'h0, 1, 2'd3, 1, 0, 0);
        add("lh1fff", 0, 3'b001, 32'h1FFF, 32'h0, 32'h0, 1, 2'd2, 1, 0, 0);
        add("lw1ffe", 0, 3'b010, 32'h1FFE, 32'h0, 32'h0, 1, 2'd2, 1, 0, 0);
        add("lw1ffc", 0, 3'b010, 32'h1FFC, 32'h0, 32'h0, 0, 2'd0, 3, 0, 1);
`ifdef MEM_ACCESS_SPLIT_EN
        add("sw22", 1, 3'b010, 32'h22, 32'h11223344, 32'h0, 0, 2'd0, 5, 2, 2,
            1, 13'h24, 4'b0011, 32'h00001122);
        add("lw22", 0, 3'b010, 32'h22, 32'h0, 32'h11223344, 0, 2'd0, 5, 0, 2);
        add("lw20b", 0, 3'b010, 32'h20, 32'h0, 32'h3344A500, 0, 2'd0, 3, 0, 1);
        add("lw24", 0, 3'b010, 32'h24, 32'h0, 32'h00001122, 0, 2'd0, 3, 0, 1);
        add("lh23", 0, 3'b001, 32'h23, 32'h0, 32'h00002233, 0, 2'd0, 5, 0, 2);
`else
        add("lw22", 0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 2'd1, 1, 0, 0);
        add("sw22", 1, 3'b010, 32'h22, 32'h11223344, 32'h0, 1, 2'd1, 1, 0, 0);
        add("sh23", 1, 3'b001, 32'h23, 32'h7777, 32'h0, 1, 2'd1, 1, 0, 0);
        add("lw20b", 0, 3'b010, 32'h20, 32'h0, 32'h0000A500, 0, 2'd0, 3, 0, 1);
`endif

        for (int i = 0; i < vt.size(); i++) run(vt[i]);

        // Reset during the first access cycle of a store.
        @(negedge clk);
        bus.req_addr   = 32'h40;
        bus.req_funct3 = 3'b010;
        bus.req_write  = 1'b1;
        bus.req_wdata  = 32'hCAFEF00D;
        bus.req_valid  = 1'b1;
        chk("midrst.ready", 32'(bus.req_ready), 32'd1);
        w0 = wr_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.write_en", 32'(mem_write_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("midrst.noresp", 32'(seen), 32'd0);
        chk("midrst.writes", 32'(wr_cnt - w0), 32'd0);
        chk("midrst.idle", 32'(bus.req_ready), 32'd1);
        vt.delete();
        add("lw40", 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 2'd0, 3, 0, 1);
        run(vt[0]);

        // Response held under backpressure.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_addr   = 32'h21;
        bus.req_funct3 = 3'b100;
        bus.req_write  = 1'b0;
        bus.req_valid  = 1'b1;
        sb.push_back('{32'h000000A5, 1'b0, 2'd0});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("bp.resp", 32'(seen), 32'd1);
        if (seen) begin
            resp_t e;
            e = sb.pop_front();
            for (int k = 0; k < 5; k++) begin
                chk("bp.valid", 32'(bus.resp_valid), 32'd1);
                chk("bp.rdata", bus.resp_rdata, e.rdata);
                chk("bp.busy", 32'(bus.req_ready), 32'd0);
                @(negedge clk);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.released", 32'(bus.resp_valid), 32'd0);
        chk("bp.ready", 32'(bus.req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
